vc_input_unit: RTL and testbench

- Router input port holding VC_NUM virtual channels behind one physical link.
- Each VC has its own flit FIFO and packet FSM (IDLE/WAITING/ACTIVE) and presents its header to the VC/switch allocator.
- A round-robin arbiter picks one ready VC per cycle onto the shared output.
- Adds over single-VC buffering: per-VC write steering, single-flit packets, fair output multiplexing and a protocol-error flag.

---
 rtl/vc_input_unit_pkg.sv | 32 +++
 rtl/vc_input_unit_if.sv | 36 +++
 rtl/vc_input_unit_rr_arbiter.sv | 41 ++++
 rtl/vc_input_unit.sv | 135 +++++++++++++
 tb/tb_vc_input_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_input_unit_pkg.sv
// Shared flit-type codes, per-VC packet states and default geometry for the VC input unit.
package vc_input_unit_pkg;

   localparam int unsigned VC_NUM_DEF      = 2;
   localparam int unsigned VC_DEPTH_W_DEF  = 2;
   localparam int unsigned FLIT_DATA_W_DEF = 8;
   localparam int unsigned FLIT_ID_W_DEF   = 2;

   typedef enum logic [1:0] {
      FLIT_SINGLE = 2'b00,
      FLIT_HEADER = 2'b01,
      FLIT_BODY   = 2'b10,
      FLIT_TAIL   = 2'b11
   } flit_id_e;

   typedef enum logic [2:0] {
      VC_IDLE    = 3'b001,
      VC_WAITING = 3'b010,
      VC_ACTIVE  = 3'b100
   } vc_state_e;

   // A flit that may legally start a packet
   function automatic logic is_head_id(input logic [1:0] id);
      return (id == FLIT_HEADER) || (id == FLIT_SINGLE);
   endfunction

   // A flit that closes the packet it belongs to
   function automatic logic is_last_id(input logic [1:0] id);
      return (id == FLIT_TAIL) || (id == FLIT_SINGLE);
   endfunction

endpackage

// File: rtl/vc_input_unit_if.sv
// Link, allocator and output-side signals of one router input port.
interface vc_input_unit_if
   import vc_input_unit_pkg::*;
#(
   parameter int unsigned VC_NUM      = VC_NUM_DEF,
   parameter int unsigned FLIT_DATA_W = FLIT_DATA_W_DEF,
   parameter int unsigned FLIT_ID_W   = FLIT_ID_W_DEF
);
   localparam int unsigned FLIT_W  = FLIT_DATA_W + FLIT_ID_W;
   localparam int unsigned VC_ID_W = $clog2(VC_NUM);

   logic [FLIT_W-1:0]        data_i;
   logic                     wr_en_i;
   logic [VC_ID_W-1:0]       wr_vc_i;
   logic [VC_NUM-1:0]        rdy_o;
   logic [VC_NUM-1:0]        overflow_o;
   logic [VC_NUM-1:0]        req_o;
   logic [VC_NUM*FLIT_W-1:0] header_o;
   logic [VC_NUM-1:0]        chan_alloc_i;
   logic [VC_NUM-1:0]        chan_rdy_i;
   logic [FLIT_W-1:0]        data_o;
   logic                     data_vld_o;
   logic [VC_ID_W-1:0]       data_vc_o;
   logic                     err_o;

   modport master (
      output data_i, wr_en_i, wr_vc_i, chan_alloc_i, chan_rdy_i,
      input  rdy_o, overflow_o, req_o, header_o, data_o, data_vld_o, data_vc_o, err_o
   );

   modport slave (
      input  data_i, wr_en_i, wr_vc_i, chan_alloc_i, chan_rdy_i,
      output rdy_o, overflow_o, req_o, header_o, data_o, data_vld_o, data_vc_o, err_o
   );

endinterface

// File: rtl/vc_input_unit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module vc_input_unit_rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req_i,
   input  logic         advance_i,
   output logic [N-1:0] grant_o
);
   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] idx;
   logic             found;

   // N is a power of two, so the index sum wraps naturally
   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      idx     = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = ptr_q + PTR_W'(i);
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            ptr_d        = idx + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else if (advance_i) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: per-VC flit FIFO and packet FSM, round-robin onto one registered output.
module vc_input_unit
   import vc_input_unit_pkg::*;
#(
   parameter int unsigned VC_NUM      = VC_NUM_DEF,
   parameter int unsigned VC_DEPTH_W  = VC_DEPTH_W_DEF,
   parameter int unsigned FLIT_DATA_W = FLIT_DATA_W_DEF,
   parameter int unsigned FLIT_ID_W   = FLIT_ID_W_DEF
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   vc_input_unit_if.slave bus
);
   localparam int unsigned FLIT_W  = FLIT_DATA_W + FLIT_ID_W;
   localparam int unsigned VC_ID_W = $clog2(VC_NUM);
   localparam int unsigned DEPTH   = 1 << VC_DEPTH_W;

   logic [FLIT_W-1:0]        head [VC_NUM];
   logic [VC_NUM-1:0]        empty, full, push, drop, pop, discard, elig, grant, req;
   logic [VC_NUM*FLIT_W-1:0] header;

   logic [FLIT_W-1:0]  gnt_flit;
   logic [VC_ID_W-1:0] gnt_idx;

   logic [FLIT_W-1:0]  data_q;
   logic               vld_q;
   logic [VC_ID_W-1:0] vc_q;
   logic               err_q;
   logic [VC_NUM-1:0]  ovf_q;

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      logic [FLIT_W-1:0]   mem_q [DEPTH];
      logic [VC_DEPTH_W:0] wr_ptr_q, rd_ptr_q;
      logic [FLIT_W-1:0]   hdr_q;
      vc_state_e           state_q;
      logic                sel;

      assign sel      = bus.wr_en_i && (bus.wr_vc_i == VC_ID_W'(v));
      assign empty[v] = (wr_ptr_q == rd_ptr_q);
      assign full[v]  = (wr_ptr_q[VC_DEPTH_W] != rd_ptr_q[VC_DEPTH_W]) &&
                        (wr_ptr_q[VC_DEPTH_W-1:0] == rd_ptr_q[VC_DEPTH_W-1:0]);
      assign head[v]  = mem_q[rd_ptr_q[VC_DEPTH_W-1:0]];

      // A pop in the same cycle frees the slot, so a write to a full VC is still taken
      assign pop[v]     = discard[v] | grant[v];
      assign push[v]    = sel && (!full[v] || pop[v]);
      assign drop[v]    = sel && full[v] && !pop[v];
      assign discard[v] = (state_q == VC_IDLE) && !empty[v] && !is_head_id(head[v][FLIT_W-1 -: 2]);
      assign elig[v]    = (state_q == VC_ACTIVE) && !empty[v] && bus.chan_rdy_i[v];
      assign req[v]     = (state_q == VC_WAITING);
      assign header[v*FLIT_W +: FLIT_W] = hdr_q;

      always_ff @(posedge clk_i) begin
         if (push[v]) mem_q[wr_ptr_q[VC_DEPTH_W-1:0]] <= bus.data_i;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hdr_q    <= '0;
            state_q  <= VC_IDLE;
         end else begin
            if (push[v]) wr_ptr_q <= wr_ptr_q + (VC_DEPTH_W+1)'(1);
            if (pop[v])  rd_ptr_q <= rd_ptr_q + (VC_DEPTH_W+1)'(1);
            case (state_q)
               VC_IDLE: begin
                  // The header stays queued; it is forwarded as the first flit once active
                  if (!empty[v] && is_head_id(head[v][FLIT_W-1 -: 2])) begin
                     state_q <= VC_WAITING;
                     hdr_q   <= head[v];
                  end
               end
               VC_WAITING: begin
                  if (bus.chan_alloc_i[v]) state_q <= VC_ACTIVE;
               end
               VC_ACTIVE: begin
                  if (grant[v] && is_last_id(head[v][FLIT_W-1 -: 2])) begin
                     state_q <= VC_IDLE;
                     hdr_q   <= '0;
                  end
               end
               default: state_q <= VC_IDLE;
            endcase
         end
      end
   end

   vc_input_unit_rr_arbiter #(.N(VC_NUM)) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (elig),
      .advance_i (|elig),
      .grant_o   (grant)
   );

   always_comb begin
      gnt_idx  = '0;
      gnt_flit = '0;
      for (int unsigned i = 0; i < VC_NUM; i++) begin
         if (grant[i]) begin
            gnt_idx  = VC_ID_W'(i);
            gnt_flit = head[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         vld_q  <= 1'b0;
         vc_q   <= '0;
         err_q  <= 1'b0;
         ovf_q  <= '0;
      end else begin
         vld_q <= |grant;
         err_q <= |discard;
         ovf_q <= drop;
         if (|grant) begin
            data_q <= gnt_flit;
            vc_q   <= gnt_idx;
         end
      end
   end

   assign bus.rdy_o      = ~full;
   assign bus.overflow_o = ovf_q;
   assign bus.req_o      = req;
   assign bus.header_o   = header;
   assign bus.data_o     = data_q;
   assign bus.data_vld_o = vld_q;
   assign bus.data_vc_o  = vc_q;
   assign bus.err_o      = err_q;

endmodule

// File: tb/tb_vc_input_unit.sv
// Self-checking bench for vc_input_unit: directed scenarios plus a randomized packet-level model.
module tb_vc_input_unit;
   import vc_input_unit_pkg::*;

   localparam int unsigned VC_NUM      = 2;
   localparam int unsigned VC_DEPTH_W  = 2;
   localparam int unsigned FLIT_DATA_W = 8;
   localparam int unsigned FLIT_ID_W   = 2;
   localparam int unsigned FLIT_W      = FLIT_DATA_W + FLIT_ID_W;
   localparam int unsigned VC_ID_W     = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vc_input_unit_if #(.VC_NUM(VC_NUM), .FLIT_DATA_W(FLIT_DATA_W), .FLIT_ID_W(FLIT_ID_W)) vif ();

   vc_input_unit #(
      .VC_NUM(VC_NUM), .VC_DEPTH_W(VC_DEPTH_W), .FLIT_DATA_W(FLIT_DATA_W), .FLIT_ID_W(FLIT_ID_W)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (vif)
   );

   typedef struct {
      logic [FLIT_W-1:0]  flit;
      logic [VC_ID_W-1:0] vc;
      int                 cyc;
   } obs_t;

   int   tests_run = 0;
   int   fails = 0;
   int   cyc = 0;
   obs_t out_q[$];
   int   err_cnt = 0;
   int   ovf_cnt0 = 0;
   int   ovf_cnt1 = 0;
   int   rr_next = 0;  // model: VC the arbiter favours next

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (vif.data_vld_o) out_q.push_back('{vif.data_o, vif.data_vc_o, cyc});
         if (vif.err_o) err_cnt++;
         if (vif.overflow_o[0]) ovf_cnt0++;
         if (vif.overflow_o[1]) ovf_cnt1++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_flit(input int v, input logic [1:0] id, input logic [7:0] pay);
      vif.wr_vc_i = VC_ID_W'(v);
      vif.data_i  = {id, pay};
      vif.wr_en_i = 1'b1;
      tick();
      vif.wr_en_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      vif.wr_en_i = 1'b0; vif.wr_vc_i = '0; vif.data_i = '0;
      vif.chan_alloc_i = '0; vif.chan_rdy_i = '0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++; if (vif.rdy_o !== 2'b11) begin fails++; $display("FAIL reset_rdy got %b want 11", vif.rdy_o); end
      tests_run++; if (vif.req_o !== 2'b00) begin fails++; $display("FAIL reset_req got %b want 00", vif.req_o); end
      tests_run++; if (vif.overflow_o !== 2'b00) begin fails++; $display("FAIL reset_ovf got %b want 00", vif.overflow_o); end
      tests_run++; if (vif.header_o !== 20'h0) begin fails++; $display("FAIL reset_header got %h want 0", vif.header_o); end
      tests_run++; if (vif.data_vld_o !== 1'b0) begin fails++; $display("FAIL reset_vld got %b want 0", vif.data_vld_o); end
      tests_run++; if (vif.data_o !== 10'h0) begin fails++; $display("FAIL reset_data got %h want 0", vif.data_o); end
      tests_run++; if (vif.data_vc_o !== 1'b0) begin fails++; $display("FAIL reset_vc got %b want 0", vif.data_vc_o); end
      tests_run++; if (vif.err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", vif.err_o); end
      rst_n = 1'b1;
      rr_next = 0;
      tick();
   endtask

   task automatic test_single_packet();
      int base;
      logic [FLIT_W-1:0] exp [3];
      exp[0] = {FLIT_HEADER, 8'h41}; exp[1] = {FLIT_BODY, 8'h82}; exp[2] = {FLIT_TAIL, 8'hC3};
      base = out_q.size();
      vif.chan_rdy_i = '1;
      write_flit(0, FLIT_HEADER, 8'h41);
      write_flit(0, FLIT_BODY, 8'h82);
      write_flit(0, FLIT_TAIL, 8'hC3);
      for (int i = 0; i < 20 && !vif.req_o[0]; i++) tick();
      tests_run++; if (vif.req_o[0] !== 1'b1) begin fails++; $display("FAIL pkt_req got %b want 1", vif.req_o[0]); end
      tests_run++; if (vif.header_o[9:0] !== exp[0]) begin fails++; $display("FAIL pkt_header got %h want %h", vif.header_o[9:0], exp[0]); end
      vif.chan_alloc_i = 2'b01;
      tick();
      vif.chan_alloc_i = '0;
      repeat (6) tick();
      tests_run++; if (out_q.size() - base !== 3) begin fails++; $display("FAIL pkt_count got %0d want 3", out_q.size() - base); end
      if (out_q.size() - base == 3) begin
         for (int i = 0; i < 3; i++) begin
            tests_run++; if (out_q[base+i].flit !== exp[i] || out_q[base+i].vc !== 1'b0)
               begin fails++; $display("FAIL pkt_flit%0d got %h/vc%0d want %h/vc0", i, out_q[base+i].flit, out_q[base+i].vc, exp[i]); end
            tests_run++; if (out_q[base+i].cyc !== out_q[base].cyc + i)
               begin fails++; $display("FAIL pkt_consec%0d got cyc %0d want %0d", i, out_q[base+i].cyc, out_q[base].cyc + i); end
         end
      end
      tests_run++; if (vif.req_o[0] !== 1'b0) begin fails++; $display("FAIL pkt_idle_req got %b want 0", vif.req_o[0]); end
      tests_run++; if (vif.header_o[9:0] !== 10'h0) begin fails++; $display("FAIL pkt_hdr_clear got %h want 0", vif.header_o[9:0]); end
      rr_next = 1;
   endtask

   task automatic test_back_to_back();
      int base;
      int want_vc;
      int k0, k1;
      logic [FLIT_W-1:0] p0 [3];
      logic [FLIT_W-1:0] p1 [3];
      logic [FLIT_W-1:0] want;
      p0[0] = {FLIT_HEADER, 8'($urandom)}; p0[1] = {FLIT_BODY, 8'($urandom)}; p0[2] = {FLIT_TAIL, 8'($urandom)};
      p1[0] = {FLIT_HEADER, 8'($urandom)}; p1[1] = {FLIT_BODY, 8'($urandom)}; p1[2] = {FLIT_TAIL, 8'($urandom)};
      base = out_q.size();
      for (int i = 0; i < 3; i++) begin
         write_flit(0, p0[i][9:8], p0[i][7:0]);
         write_flit(1, p1[i][9:8], p1[i][7:0]);
      end
      for (int i = 0; i < 20 && vif.req_o !== 2'b11; i++) tick();
      tests_run++; if (vif.req_o !== 2'b11) begin fails++; $display("FAIL b2b_req got %b want 11", vif.req_o); end
      vif.chan_alloc_i = 2'b11;
      tick();
      vif.chan_alloc_i = '0;
      repeat (10) tick();
      tests_run++; if (out_q.size() - base !== 6) begin fails++; $display("FAIL b2b_count got %0d want 6", out_q.size() - base); end
      if (out_q.size() - base == 6) begin
         want_vc = rr_next; k0 = 0; k1 = 0;
         for (int i = 0; i < 6; i++) begin
            if (want_vc == 0) begin want = p0[k0]; k0++; end else begin want = p1[k1]; k1++; end
            tests_run++; if (out_q[base+i].vc !== VC_ID_W'(want_vc) || out_q[base+i].flit !== want)
               begin fails++; $display("FAIL b2b_seq%0d got %h/vc%0d want %h/vc%0d", i, out_q[base+i].flit, out_q[base+i].vc, want, want_vc); end
            rr_next = 1 - want_vc;
            want_vc = 1 - want_vc;
         end
      end
   endtask

   task automatic test_single_flit();
      int base;
      base = out_q.size();
      write_flit(1, FLIT_SINGLE, 8'h15);
      for (int i = 0; i < 20 && !vif.req_o[1]; i++) tick();
      tests_run++; if (vif.req_o[1] !== 1'b1) begin fails++; $display("FAIL single_req got %b want 1", vif.req_o[1]); end
      tests_run++; if (vif.header_o[19:10] !== 10'h015) begin fails++; $display("FAIL single_header got %h want 015", vif.header_o[19:10]); end
      vif.chan_alloc_i = 2'b10;
      tick();
      vif.chan_alloc_i = '0;
      repeat (5) tick();
      tests_run++; if (out_q.size() - base !== 1) begin fails++; $display("FAIL single_count got %0d want 1", out_q.size() - base); end
      if (out_q.size() - base == 1) begin
         tests_run++; if (out_q[base].flit !== 10'h015 || out_q[base].vc !== 1'b1)
            begin fails++; $display("FAIL single_flit got %h/vc%0d want 015/vc1", out_q[base].flit, out_q[base].vc); end
      end
      tests_run++; if (vif.req_o[1] !== 1'b0 || vif.header_o[19:10] !== 10'h0)
         begin fails++; $display("FAIL single_idle got req %b hdr %h want 0/0", vif.req_o[1], vif.header_o[19:10]); end
      rr_next = 0;
   endtask

   task automatic test_overflow();
      int base, ob, eb;
      logic [FLIT_W-1:0] w [4];
      w[0] = {FLIT_HEADER, 8'($urandom)}; w[1] = {FLIT_BODY, 8'($urandom)};
      w[2] = {FLIT_BODY, 8'($urandom)};   w[3] = {FLIT_TAIL, 8'($urandom)};
      base = out_q.size(); ob = ovf_cnt0; eb = err_cnt;
      vif.chan_alloc_i = '0;
      for (int i = 0; i < 4; i++) write_flit(0, w[i][9:8], w[i][7:0]);
      tests_run++; if (vif.rdy_o[0] !== 1'b0) begin fails++; $display("FAIL ovf_full_rdy got %b want 0", vif.rdy_o[0]); end
      write_flit(0, FLIT_BODY, 8'hEE);
      tests_run++; if (vif.overflow_o[0] !== 1'b1) begin fails++; $display("FAIL ovf_pulse got %b want 1", vif.overflow_o[0]); end
      tick();
      tests_run++; if (vif.overflow_o[0] !== 1'b0) begin fails++; $display("FAIL ovf_pulse_end got %b want 0", vif.overflow_o[0]); end
      vif.chan_alloc_i = 2'b01;
      tick();
      vif.chan_alloc_i = '0;
      repeat (8) tick();
      tests_run++; if (ovf_cnt0 - ob !== 1) begin fails++; $display("FAIL ovf_once got %0d want 1", ovf_cnt0 - ob); end
      tests_run++; if (out_q.size() - base !== 4) begin fails++; $display("FAIL ovf_drain_count got %0d want 4", out_q.size() - base); end
      if (out_q.size() - base == 4) begin
         for (int i = 0; i < 4; i++) begin
            tests_run++; if (out_q[base+i].flit !== w[i] || out_q[base+i].vc !== 1'b0)
               begin fails++; $display("FAIL ovf_drain%0d got %h/vc%0d want %h/vc0", i, out_q[base+i].flit, out_q[base+i].vc, w[i]); end
         end
      end
      tests_run++; if (err_cnt - eb !== 0) begin fails++; $display("FAIL ovf_no_err got %0d want 0", err_cnt - eb); end
      tests_run++; if (vif.rdy_o[0] !== 1'b1) begin fails++; $display("FAIL ovf_rdy_back got %b want 1", vif.rdy_o[0]); end
      rr_next = 1;
   endtask

   task automatic test_error();
      int base, eb;
      base = out_q.size(); eb = err_cnt;
      write_flit(1, FLIT_BODY, 8'($urandom));
      tick();
      tests_run++; if (vif.err_o !== 1'b1) begin fails++; $display("FAIL err_pulse got %b want 1", vif.err_o); end
      tick();
      tests_run++; if (vif.err_o !== 1'b0) begin fails++; $display("FAIL err_pulse_end got %b want 0", vif.err_o); end
      repeat (3) tick();
      tests_run++; if (err_cnt - eb !== 1) begin fails++; $display("FAIL err_once got %0d want 1", err_cnt - eb); end
      tests_run++; if (vif.req_o[1] !== 1'b0 || vif.header_o[19:10] !== 10'h0)
         begin fails++; $display("FAIL err_idle got req %b hdr %h want 0/0", vif.req_o[1], vif.header_o[19:10]); end
      tests_run++; if (vif.rdy_o[1] !== 1'b1) begin fails++; $display("FAIL err_discard got rdy %b want 1", vif.rdy_o[1]); end
      tests_run++; if (out_q.size() - base !== 0) begin fails++; $display("FAIL err_no_out got %0d want 0", out_q.size() - base); end
   endtask

   task automatic test_stall();
      int base;
      logic [FLIT_W-1:0] w [4];
      w[0] = {FLIT_HEADER, 8'($urandom)}; w[1] = {FLIT_BODY, 8'($urandom)};
      w[2] = {FLIT_BODY, 8'($urandom)};   w[3] = {FLIT_TAIL, 8'($urandom)};
      base = out_q.size();
      vif.chan_rdy_i = 2'b11;
      for (int i = 0; i < 4; i++) write_flit(0, w[i][9:8], w[i][7:0]);
      for (int i = 0; i < 20 && !vif.req_o[0]; i++) tick();
      vif.chan_alloc_i = 2'b01;
      tick();
      vif.chan_alloc_i = '0;
      for (int i = 0; i < 20 && !vif.data_vld_o; i++) tick();
      tests_run++; if (vif.data_vld_o !== 1'b1 || vif.data_o !== w[0])
         begin fails++; $display("FAIL stall_first got vld %b data %h want 1/%h", vif.data_vld_o, vif.data_o, w[0]); end
      vif.chan_rdy_i = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++; if (vif.data_vld_o !== 1'b0 || vif.data_o !== w[0])
            begin fails++; $display("FAIL stall_hold%0d got vld %b data %h want 0/%h", i, vif.data_vld_o, vif.data_o, w[0]); end
      end
      vif.chan_rdy_i = 2'b11;
      repeat (8) tick();
      tests_run++; if (out_q.size() - base !== 4) begin fails++; $display("FAIL stall_count got %0d want 4", out_q.size() - base); end
      if (out_q.size() - base == 4) begin
         for (int i = 1; i < 4; i++) begin
            tests_run++; if (out_q[base+i].flit !== w[i])
               begin fails++; $display("FAIL stall_resume%0d got %h want %h", i, out_q[base+i].flit, w[i]); end
         end
      end
      rr_next = 1;
   endtask

   logic [FLIT_W-1:0] str0[$], str1[$], exp0[$], exp1[$], got0[$], got1[$];

   task automatic push_flit(input int v, input logic [FLIT_W-1:0] f, input bit kept);
      if (v == 0) begin str0.push_back(f); if (kept) exp0.push_back(f); end
      else begin str1.push_back(f); if (kept) exp1.push_back(f); end
   endtask

   // Packet-level model: any BODY/TAIL between packets is discarded and raises one error
   task automatic test_random();
      int base, eb, ob0, ob1, strays, nb, v;
      logic [1:0] id;
      str0.delete(); str1.delete(); exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
      strays = 0;
      for (int vc = 0; vc < 2; vc++) begin
         for (int p = 0; p < 6; p++) begin
            if (vc == 1 && $urandom_range(0, 3) == 0) begin
               id = ($urandom_range(0, 1) == 1) ? FLIT_BODY : FLIT_TAIL;
               push_flit(vc, {id, 8'($urandom)}, 1'b0);
               strays++;
            end
            if ($urandom_range(0, 3) == 0) push_flit(vc, {FLIT_SINGLE, 8'($urandom)}, 1'b1);
            else begin
               nb = $urandom_range(0, 3);
               push_flit(vc, {FLIT_HEADER, 8'($urandom)}, 1'b1);
               for (int b = 0; b < nb; b++) push_flit(vc, {FLIT_BODY, 8'($urandom)}, 1'b1);
               push_flit(vc, {FLIT_TAIL, 8'($urandom)}, 1'b1);
            end
         end
      end
      base = out_q.size(); eb = err_cnt; ob0 = ovf_cnt0; ob1 = ovf_cnt1;
      for (int c = 0; c < 3000 && (str0.size() + str1.size()) > 0; c++) begin
         vif.chan_alloc_i = 2'($urandom);
         vif.chan_rdy_i   = 2'($urandom);
         v = $urandom_range(0, 1);
         if (v == 0 && str0.size() > 0 && vif.rdy_o[0]) begin
            vif.wr_vc_i = 1'b0; vif.data_i = str0.pop_front(); vif.wr_en_i = 1'b1;
         end else if (v == 1 && str1.size() > 0 && vif.rdy_o[1]) begin
            vif.wr_vc_i = 1'b1; vif.data_i = str1.pop_front(); vif.wr_en_i = 1'b1;
         end
         tick();
         vif.wr_en_i = 1'b0;
      end
      tests_run++; if (str0.size() + str1.size() !== 0) begin fails++; $display("FAIL rnd_write_timeout got %0d left want 0", str0.size() + str1.size()); end
      vif.chan_alloc_i = 2'b11; vif.chan_rdy_i = 2'b11;
      repeat (60) tick();
      for (int i = base; i < out_q.size(); i++) begin
         if (out_q[i].vc == 1'b0) got0.push_back(out_q[i].flit); else got1.push_back(out_q[i].flit);
      end
      tests_run++; if (got0.size() !== exp0.size()) begin fails++; $display("FAIL rnd_count_vc0 got %0d want %0d", got0.size(), exp0.size()); end
      tests_run++; if (got1.size() !== exp1.size()) begin fails++; $display("FAIL rnd_count_vc1 got %0d want %0d", got1.size(), exp1.size()); end
      for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
         tests_run++; if (got0[i] !== exp0[i]) begin fails++; $display("FAIL rnd_vc0_flit%0d got %h want %h", i, got0[i], exp0[i]); end
      end
      for (int i = 0; i < got1.size() && i < exp1.size(); i++) begin
         tests_run++; if (got1[i] !== exp1[i]) begin fails++; $display("FAIL rnd_vc1_flit%0d got %h want %h", i, got1[i], exp1[i]); end
      end
      tests_run++; if (err_cnt - eb !== strays) begin fails++; $display("FAIL rnd_err got %0d want %0d", err_cnt - eb, strays); end
      tests_run++; if ((ovf_cnt0 - ob0) + (ovf_cnt1 - ob1) !== 0)
         begin fails++; $display("FAIL rnd_ovf got %0d want 0", (ovf_cnt0 - ob0) + (ovf_cnt1 - ob1)); end
      tests_run++; if (vif.req_o !== 2'b00 || vif.rdy_o !== 2'b11)
         begin fails++; $display("FAIL rnd_quiesce got req %b rdy %b want 00/11", vif.req_o, vif.rdy_o); end
      vif.chan_alloc_i = '0;
   endtask

   task automatic test_reset_mid_packet();
      int base;
      vif.chan_rdy_i = 2'b11;
      write_flit(0, FLIT_HEADER, 8'h5A);
      write_flit(0, FLIT_BODY, 8'h11);
      write_flit(0, FLIT_BODY, 8'h22);
      write_flit(1, FLIT_HEADER, 8'h33);
      vif.chan_alloc_i = 2'b01;
      tick();
      vif.chan_alloc_i = '0;
      for (int i = 0; i < 20 && !vif.data_vld_o; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++; if (vif.rdy_o !== 2'b11) begin fails++; $display("FAIL mid_rst_rdy got %b want 11", vif.rdy_o); end
      tests_run++; if (vif.req_o !== 2'b00 || vif.header_o !== 20'h0)
         begin fails++; $display("FAIL mid_rst_req_hdr got %b/%h want 00/0", vif.req_o, vif.header_o); end
      tests_run++; if (vif.data_vld_o !== 1'b0 || vif.data_o !== 10'h0 || vif.data_vc_o !== 1'b0)
         begin fails++; $display("FAIL mid_rst_out got %b/%h/%b want 0/0/0", vif.data_vld_o, vif.data_o, vif.data_vc_o); end
      tests_run++; if (vif.err_o !== 1'b0 || vif.overflow_o !== 2'b00)
         begin fails++; $display("FAIL mid_rst_pulses got %b/%b want 0/00", vif.err_o, vif.overflow_o); end
      repeat (2) tick();
      rst_n = 1'b1;
      rr_next = 0;
      base = out_q.size();
      vif.chan_alloc_i = 2'b11;
      repeat (10) tick();
      vif.chan_alloc_i = '0;
      tests_run++; if (out_q.size() - base !== 0) begin fails++; $display("FAIL mid_rst_lost got %0d flits want 0", out_q.size() - base); end
      tests_run++; if (vif.req_o !== 2'b00) begin fails++; $display("FAIL mid_rst_idle got %b want 00", vif.req_o); end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_single_flit();
      test_overflow();
      test_error();
      test_stall();
      test_random();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
